// File: rtl/mike_pkg.sv
// rtl/mike_pkg.sv - shared opcodes, sequencer states and ALU commands for the MikeCPU core
//
// Purpose: common definitions imported by mike_alu and mike_core.
// Contents: opcode values (inst[31:26]), sequencer state encoding, ALU command codes.
package mike_pkg;

  localparam logic [5:0] OP_LI   = 6'd0;
  localparam logic [5:0] OP_MR   = 6'd1;
  localparam logic [5:0] OP_ADDI = 6'd2;
  localparam logic [5:0] OP_ADD  = 6'd3;
  localparam logic [5:0] OP_SUB  = 6'd4;
  localparam logic [5:0] OP_B    = 6'd14;
  localparam logic [5:0] OP_BZ   = 6'd15;
  localparam logic [5:0] OP_OUT  = 6'd29;
  localparam logic [5:0] OP_HALT = 6'd31;

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WRITE,
    S_OUT_WAIT,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    COM_ADD,
    COM_SUB,
    COM_PASS
  } alu_cmd_t;

endpackage

// File: rtl/mike_alu.sv
// rtl/mike_alu.sv - combinational add/sub/pass ALU of parametric width
//
// Purpose: register datapath arithmetic, modulo 2^XLEN.
// Ports:
//   cmd  in   alu_cmd_t  COM_ADD: a+b, COM_SUB: a-b, COM_PASS: a
//   a    in   XLEN       first operand
//   b    in   XLEN       second operand
//   y    out  XLEN       result
module mike_alu
  import mike_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_cmd_t        cmd,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = a;
    case (cmd)
      COM_ADD:  y = a + b;
      COM_SUB:  y = a - b;
      COM_PASS: y = a;
      default:  y = a;
    endcase
  end

endmodule

// File: rtl/mike_core.sv
// rtl/mike_core.sv - multi-cycle MikeCPU core: sequencer, register file, ALU, output port
//
// Purpose: fetch/decode/exec/write core fed by an instruction-memory handshake,
//   driving a valid/ready output port.
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     fetch request (high in FETCH) and word address (= pc)
//   imem_valid/data   instruction word returned by memory
//   out_valid/ready   output handshake, out_data carries the out instruction's register
//   halted            core sits in HALT
//   err               sticky illegal-opcode flag
//   instret           retired-instruction count, wraps modulo 2^32
module mike_core
  import mike_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 4,
  parameter int PC_W  = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            halted,
  output logic            err,
  output logic [31:0]     instret
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_off, pc_next;
  logic [31:0]     inst;
  logic [XLEN-1:0] op_a, op_b, alu_y;
  alu_cmd_t        cmd;
  logic [4:0]      dest;   // 0 doubles as "no register write"
  logic [XLEN-1:0] regs [NREGS];

  // Instruction fields (bit 0 of the ISA numbering is the MSB)
  logic [5:0]      opc;
  logic [4:0]      f_rd, f_ra, f_rb;
  logic [XLEN-1:0] imm16_x;
  assign opc     = inst[31:26];
  assign f_rd    = inst[25:21];
  assign f_ra    = inst[20:16];
  assign f_rb    = inst[15:11];
  assign imm16_x = XLEN'($signed(inst[15:0]));

  // r0 and indices beyond the register file read as zero and drop writes
  function automatic logic reg_ok(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NREGS);
  endfunction

  logic [XLEN-1:0] rv_a, rv_b, rv_d;
  always_comb begin
    rv_a = '0;
    rv_b = '0;
    rv_d = '0;
    if (reg_ok(f_ra)) rv_a = regs[f_ra[RIDX_W-1:0]];
    if (reg_ok(f_rb)) rv_b = regs[f_rb[RIDX_W-1:0]];
    if (reg_ok(f_rd)) rv_d = regs[f_rd[RIDX_W-1:0]];
  end

  // Operand/command selection, latched on the DECODE cycle
  logic [XLEN-1:0] dec_a, dec_b;
  alu_cmd_t        dec_cmd;
  logic            dec_wr, dec_legal;
  always_comb begin
    dec_a     = rv_a;
    dec_b     = rv_b;
    dec_cmd   = COM_ADD;
    dec_wr    = 1'b0;
    dec_legal = 1'b1;
    case (opc)
      OP_LI:   begin dec_a = '0; dec_b = imm16_x; dec_wr = 1'b1; end
      OP_MR:   begin dec_cmd = COM_PASS; dec_wr = 1'b1; end
      OP_ADDI: begin dec_b = imm16_x; dec_wr = 1'b1; end
      OP_ADD:  dec_wr = 1'b1;
      OP_SUB:  begin dec_cmd = COM_SUB; dec_wr = 1'b1; end
      OP_OUT:  begin dec_a = rv_d; dec_cmd = COM_PASS; end
      OP_B, OP_BZ, OP_HALT: ;
      default: dec_legal = 1'b0;
    endcase
  end

  // Dedicated PC adder; bz tests rA through op_a, which DECODE loaded with rA
  always_comb begin
    pc_off = PC_W'(1);
    if (opc == OP_B)
      pc_off = PC_W'($signed(inst[25:0]));
    else if (opc == OP_BZ && op_a == '0)
      pc_off = PC_W'($signed(inst[15:0]));
  end
  assign pc_next = pc + pc_off;

  mike_alu #(.XLEN(XLEN)) u_alu (
    .cmd (cmd),
    .a   (op_a),
    .b   (op_b),
    .y   (alu_y)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:     state_nxt = S_FETCH;
      S_FETCH:    if (imem_valid) state_nxt = S_DECODE;
      S_DECODE:   state_nxt = dec_legal ? S_EXEC : S_HALT;
      S_EXEC:     state_nxt = (opc == OP_OUT) ? S_OUT_WAIT : S_WRITE;
      S_WRITE:    state_nxt = (opc == OP_HALT) ? S_HALT : S_FETCH;
      S_OUT_WAIT: if (out_ready) state_nxt = S_FETCH;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_INIT;
      pc        <= '0;
      inst      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      cmd       <= COM_ADD;
      dest      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      instret   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: if (imem_valid) inst <= imem_data;
        S_DECODE: begin
          op_a <= dec_a;
          op_b <= dec_b;
          cmd  <= dec_cmd;
          dest <= dec_wr ? f_rd : 5'd0;
          if (!dec_legal) err <= 1'b1;
        end
        S_EXEC: begin
          if (reg_ok(dest)) regs[dest[RIDX_W-1:0]] <= alu_y;
          if (opc == OP_OUT) begin
            out_data  <= alu_y;
            out_valid <= 1'b1;
          end
        end
        S_WRITE: begin
          if (opc != OP_HALT) pc <= pc_next;
          instret <= instret + 32'd1;
        end
        // out_valid is already high here, so out_ready alone completes the handshake
        S_OUT_WAIT: if (out_ready) begin
          out_valid <= 1'b0;
          pc        <= pc_next;
          instret   <= instret + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_mike_core.sv
// tb/tb_mike_core.sv - self-checking bench for mike_core (XLEN=16, NREGS=8, PC_W=16)
module tb_mike_core;

  localparam int XLEN  = 16;
  localparam int NREGS = 8;
  localparam int PC_W  = 16;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_data;
  logic            halted;
  logic            err;
  logic [31:0]     instret;

  mike_core #(.XLEN(XLEN), .NREGS(NREGS), .PC_W(PC_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .halted     (halted),
    .err        (err),
    .instret    (instret)
  );

  always #5 CLK = ~CLK;

  // Instruction memory with a random number of wait cycles per fetch
  logic [31:0] mem [256];
  int          max_wait = 0;
  int          wait_left = 0;
  int          cyc = 0;
  assign imem_data  = mem[imem_addr[7:0]];
  assign imem_valid = (wait_left == 0);

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (imem_req) begin
      if (wait_left == 0) wait_left <= int'($urandom_range(0, max_wait));
      else                wait_left <= wait_left - 1;
    end
  end

  // Output consumer: 0 = always ready, 1 = random, 2 = manual_ready
  int              ready_mode = 0;
  logic            manual_ready = 1'b0;
  logic [XLEN-1:0] got_q[$];
  int              got_t[$];
  int              got_ir[$];

  always @(negedge CLK) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = manual_ready;
    endcase
    if (RST_N && out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_t.push_back(cyc);
      got_ir.push_back(int'(instret));
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint got(input int i);
    return (i < got_q.size()) ? longint'(got_q[i]) : -1;
  endfunction

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] ra, input logic [15:0] imm);
    return {op, rd, ra, imm};
  endfunction

  function automatic logic [31:0] enc_rr(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] ra, input logic [4:0] rb);
    return {op, rd, ra, rb, 11'b0};
  endfunction

  function automatic logic [31:0] enc_b(input int off);
    logic [25:0] o;
    o = off[25:0];
    return {6'd14, o};
  endfunction

  logic [31:0] prog[$];

  task automatic load_prog();
    for (int i = 0; i < 256; i++)
      mem[i] = (i < prog.size()) ? prog[i] : enc(6'd31, 5'd0, 5'd0, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    got_q.delete();
    got_t.delete();
    got_ir.delete();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_halt_reached"}, halted, 1);
  endtask

  task automatic wait_outs(input string name, input int cnt, input int budget);
    int n;
    n = 0;
    while (got_q.size() < cnt && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_out_count"}, got_q.size(), cnt);
  endtask

  // ISA-level reference: walks the program one instruction at a time
  logic [XLEN-1:0] exp_q[$];

  task automatic run_model(output int ir, output logic e);
    logic [15:0] r[32];
    logic [15:0] pc, v;
    logic [31:0] w;
    logic [4:0]  rd, ra, rb;
    bit          done, wr;
    for (int i = 0; i < 32; i++) r[i] = '0;
    pc = '0; ir = 0; e = 1'b0; done = 1'b0;
    exp_q.delete();
    for (int step = 0; step < 5000 && !done; step++) begin
      w = mem[pc[7:0]];
      rd = w[25:21]; ra = w[20:16]; rb = w[15:11];
      wr = 1'b0; v = '0;
      case (w[31:26])
        6'd0:  begin v = w[15:0];          wr = 1'b1; end
        6'd1:  begin v = r[ra];            wr = 1'b1; end
        6'd2:  begin v = r[ra] + w[15:0];  wr = 1'b1; end
        6'd3:  begin v = r[ra] + r[rb];    wr = 1'b1; end
        6'd4:  begin v = r[ra] - r[rb];    wr = 1'b1; end
        6'd14, 6'd15: ;
        6'd29: exp_q.push_back(r[rd]);
        6'd31: done = 1'b1;
        default: begin e = 1'b1; done = 1'b1; end
      endcase
      if (wr && rd != 0 && int'(rd) < NREGS) r[rd] = v;
      if (!e) ir++;
      if (w[31:26] == 6'd14)      pc = pc + w[15:0];
      else if (w[31:26] == 6'd15) pc = (r[ra] == 0) ? pc + w[15:0] : pc + 16'd1;
      else if (!done)             pc = pc + 16'd1;
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    logic [31:0] third;
    int          m_ir, budget;
    logic        m_err;
    int          fib[7];

    vecs[0] = '{6'd3, 16'h0005, 16'h0007, 16'h000C};
    vecs[1] = '{6'd4, 16'h0005, 16'h0007, 16'hFFFE};
    vecs[2] = '{6'd3, 16'h7FFF, 16'h0001, 16'h8000};
    vecs[3] = '{6'd3, 16'hFFFF, 16'h0001, 16'h0000};
    vecs[4] = '{6'd2, 16'h0100, 16'hFF00, 16'h0000};
    vecs[5] = '{6'd1, 16'hABCD, 16'h0000, 16'hABCD};
    vecs[6] = '{6'd0, 16'h0000, 16'h8001, 16'h8001};
    vecs[7] = '{6'd4, 16'h8000, 16'h0001, 16'h7FFF};
    fib = '{1, 1, 2, 3, 5, 8, 13};

    prog.delete();
    load_prog();

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instret", instret, 0);
    RST_N = 1'b1;

    // Table: li r1,a; li r2,b; <op> r3; out r3; halt
    for (int v = 0; v < 8; v++) begin
      case (vecs[v].op)
        6'd0:    third = enc(6'd0, 5'd3, 5'd0, vecs[v].b);
        6'd1:    third = enc(6'd1, 5'd3, 5'd1, 16'd0);
        6'd2:    third = enc(6'd2, 5'd3, 5'd1, vecs[v].b);
        default: third = enc_rr(vecs[v].op, 5'd3, 5'd1, 5'd2);
      endcase
      prog.delete();
      prog.push_back(enc(6'd0, 5'd1, 5'd0, vecs[v].a));
      prog.push_back(enc(6'd0, 5'd2, 5'd0, vecs[v].b));
      prog.push_back(third);
      prog.push_back(enc(6'd29, 5'd3, 5'd0, 16'd0));
      prog.push_back(enc(6'd31, 5'd0, 5'd0, 16'd0));
      load_prog();
      do_reset();
      wait_halt($sformatf("vec%0d", v), 200);
      chk($sformatf("vec%0d_nout", v), got_q.size(), 1);
      chk($sformatf("vec%0d_value", v), got(0), vecs[v].exp);
      chk($sformatf("vec%0d_instret", v), instret, 5);
    end

    // Fibonacci, zero-wait memory, always ready
    prog.delete();
    prog.push_back(enc(6'd1, 5'd1, 5'd0, 16'd0));
    prog.push_back(enc(6'd2, 5'd1, 5'd1, 16'd1));
    prog.push_back(enc(6'd1, 5'd2, 5'd0, 16'd0));
    prog.push_back(enc(6'd1, 5'd3, 5'd0, 16'd0));
    prog.push_back(enc(6'd29, 5'd1, 5'd0, 16'd0));
    prog.push_back(enc(6'd1, 5'd3, 5'd2, 16'd0));
    prog.push_back(enc(6'd1, 5'd2, 5'd1, 16'd0));
    prog.push_back(enc_rr(6'd3, 5'd1, 5'd2, 5'd3));
    prog.push_back(enc_b(-4));
    load_prog();
    max_wait = 0; ready_mode = 0;
    do_reset();
    wait_outs("fib", 7, 400);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("fib_val%0d", k), got(k), fib[k]);
      if (k < got_ir.size()) chk($sformatf("fib_ir%0d", k), got_ir[k], 4 + 5 * k);
      if (k > 0 && k < got_t.size()) chk($sformatf("fib_gap%0d", k), got_t[k] - got_t[k-1], 20);
    end

    // Fibonacci with imem wait states and random out_ready
    max_wait = 5; ready_mode = 1;
    do_reset();
    wait_outs("fibw", 7, 3000);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("fibw_val%0d", k), got(k), fib[k]);
      if (k < got_ir.size()) chk($sformatf("fibw_ir%0d", k), got_ir[k], 4 + 5 * k);
    end
    max_wait = 0; ready_mode = 0;

    // Output backpressure for 7 cycles
    prog.delete();
    prog.push_back(enc(6'd0, 5'd1, 5'd0, 16'h1234));
    prog.push_back(enc(6'd29, 5'd1, 5'd0, 16'd0));
    prog.push_back(enc(6'd31, 5'd0, 5'd0, 16'd0));
    load_prog();
    manual_ready = 1'b0; ready_mode = 2;
    do_reset();
    budget = 0;
    while (!out_valid && budget < 100) begin
      @(negedge CLK);
      budget++;
    end
    chk("bp_valid_seen", out_valid, 1);
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      chk($sformatf("bp_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_data%0d", k), out_data, 16'h1234);
      chk($sformatf("bp_req%0d", k), imem_req, 0);
      chk($sformatf("bp_pc%0d", k), imem_addr, 1);
    end
    chk("bp_no_early_hs", got_q.size(), 0);
    manual_ready = 1'b1;
    wait_halt("bp", 100);
    chk("bp_single_hs", got_q.size(), 1);
    chk("bp_instret", instret, 3);
    ready_mode = 0;

    // bz, 16-bit wrap
    prog.delete();
    prog.push_back(enc(6'd0, 5'd1, 5'd0, 16'h7FFF));
    prog.push_back(enc(6'd2, 5'd1, 5'd1, 16'd1));
    prog.push_back(enc(6'd29, 5'd1, 5'd0, 16'd0));
    prog.push_back(enc(6'd15, 5'd0, 5'd0, 16'd2));
    prog.push_back(enc(6'd0, 5'd2, 5'd0, 16'd1));
    prog.push_back(enc(6'd29, 5'd2, 5'd0, 16'd0));
    prog.push_back(enc(6'd15, 5'd0, 5'd1, 16'd2));
    prog.push_back(enc(6'd0, 5'd2, 5'd0, 16'd7));
    prog.push_back(enc(6'd29, 5'd2, 5'd0, 16'd0));
    prog.push_back(enc(6'd31, 5'd0, 5'd0, 16'd0));
    load_prog();
    do_reset();
    wait_halt("bz", 300);
    chk("bz_nout", got_q.size(), 3);
    chk("bz_wrap", got(0), 16'h8000);
    chk("bz_taken", got(1), 0);
    chk("bz_fallthru", got(2), 7);
    chk("bz_instret", instret, 9);

    // Register-index edges
    prog.delete();
    prog.push_back(enc(6'd0, 5'd7, 5'd0, 16'd5));
    prog.push_back(enc(6'd29, 5'd7, 5'd0, 16'd0));
    prog.push_back(enc(6'd0, 5'd9, 5'd0, 16'd3));
    prog.push_back(enc(6'd29, 5'd9, 5'd0, 16'd0));
    prog.push_back(enc(6'd0, 5'd0, 5'd0, 16'd4));
    prog.push_back(enc(6'd29, 5'd0, 5'd0, 16'd0));
    prog.push_back(enc(6'd31, 5'd0, 5'd0, 16'd0));
    load_prog();
    do_reset();
    wait_halt("regs", 300);
    chk("regs_r7", got(0), 5);
    chk("regs_r9", got(1), 0);
    chk("regs_r0", got(2), 0);
    chk("regs_instret", instret, 7);

    // Illegal opcode at pc=2
    prog.delete();
    prog.push_back(enc(6'd0, 5'd1, 5'd0, 16'd1));
    prog.push_back(enc(6'd0, 5'd2, 5'd0, 16'd2));
    prog.push_back(enc(6'd6, 5'd0, 5'd0, 16'd0));
    prog.push_back(enc(6'd29, 5'd1, 5'd0, 16'd0));
    load_prog();
    do_reset();
    budget = 0;
    while (!(imem_req && imem_valid && imem_addr == 2) && budget < 100) begin
      @(negedge CLK);
      budget++;
    end
    chk("ill_fetch_pc2", imem_addr, 2);
    repeat (2) @(negedge CLK);
    chk("ill_err", err, 1);
    chk("ill_halted", halted, 1);
    chk("ill_instret", instret, 2);
    repeat (5) @(negedge CLK);
    chk("ill_still_halted", halted, 1);
    chk("ill_no_req", imem_req, 0);
    chk("ill_err_sticky", err, 1);
    chk("ill_no_out", got_q.size(), 0);

    // Reset pulse while the out instruction is in EXEC
    prog.delete();
    prog.push_back(enc(6'd0, 5'd1, 5'd0, 16'd9));
    prog.push_back(enc(6'd29, 5'd1, 5'd0, 16'd0));
    prog.push_back(enc(6'd31, 5'd0, 5'd0, 16'd0));
    load_prog();
    do_reset();
    budget = 0;
    while (!(imem_req && imem_valid && imem_addr == 1) && budget < 100) begin
      @(negedge CLK);
      budget++;
    end
    repeat (2) @(negedge CLK);
    chk("mid_pre_instret", instret, 1);
    RST_N = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_instret", instret, 0);
    chk("mid_err", err, 0);
    chk("mid_halted", halted, 0);
    chk("mid_req", imem_req, 0);
    chk("mid_addr", imem_addr, 0);
    @(negedge CLK);
    got_q.delete(); got_t.delete(); got_ir.delete();
    RST_N = 1'b1;
    budget = 0;
    while (!imem_req && budget < 20) begin
      @(negedge CLK);
      budget++;
    end
    chk("mid_refetch_pc0", imem_addr, 0);
    wait_halt("mid", 200);
    chk("mid_out", got(0), 9);
    chk("mid_nout", got_q.size(), 1);
    chk("mid_final_instret", instret, 3);

    // Random straight-line programs with forward bz, waits and backpressure
    max_wait = 5; ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      prog.delete();
      for (int i = 0; i < 24; i++) begin
        logic [4:0]  rd, ra, rb;
        logic [15:0] imm;
        rd  = 5'($urandom_range(0, 9));
        ra  = 5'($urandom_range(0, 9));
        rb  = 5'($urandom_range(0, 9));
        imm = 16'($urandom);
        case ($urandom_range(0, 7))
          0:       prog.push_back(enc(6'd0, rd, 5'd0, imm));
          1:       prog.push_back(enc(6'd1, rd, ra, 16'd0));
          2:       prog.push_back(enc(6'd2, rd, ra, imm));
          3:       prog.push_back(enc_rr(6'd3, rd, ra, rb));
          4:       prog.push_back(enc_rr(6'd4, rd, ra, rb));
          7:       prog.push_back(enc(6'd15, 5'd0, ra, 16'($urandom_range(1, 3))));
          default: prog.push_back(enc(6'd29, rd, 5'd0, 16'd0));
        endcase
      end
      load_prog();
      run_model(m_ir, m_err);
      do_reset();
      wait_halt($sformatf("rnd%0d", t), 4000);
      chk($sformatf("rnd%0d_nout", t), got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
        chk($sformatf("rnd%0d_out%0d", t, k), got(k), exp_q[k]);
      chk($sformatf("rnd%0d_instret", t), instret, m_ir);
      chk($sformatf("rnd%0d_err", t), err, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
